// File: rtl/shift_sched.sv
`default_nettype none
// ============================================================================
// Module   : shift_sched
// Purpose  : Round-robin two-port front end for one shared external 32-bit
//            shifter: latch winner, drive shifter, capture, respond.
// Revision : 1.0
// ============================================================================
module shift_sched #(
    parameter int XLEN = 32,
    parameter int SHW  = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,

    input  logic            r0_req_valid,
    output logic            r0_req_ready,
    input  logic [XLEN-1:0] r0_req_data,
    input  logic [SHW-1:0]  r0_req_shamt,
    input  logic            r0_req_l_or_r,
    input  logic            r0_req_a_or_l,
    output logic            r0_resp_valid,
    input  logic            r0_resp_ready,
    output logic [XLEN-1:0] r0_resp_data,

    input  logic            r1_req_valid,
    output logic            r1_req_ready,
    input  logic [XLEN-1:0] r1_req_data,
    input  logic [SHW-1:0]  r1_req_shamt,
    input  logic            r1_req_l_or_r,
    input  logic            r1_req_a_or_l,
    output logic            r1_resp_valid,
    input  logic            r1_resp_ready,
    output logic [XLEN-1:0] r1_resp_data,

    output logic [XLEN-1:0] sh_data,
    output logic [SHW-1:0]  sh_shamt,
    output logic            sh_l_or_r,
    output logic            sh_a_or_l,
    input  logic [XLEN-1:0] sh_out_q,

    output logic            busy,
    output logic [CNTW-1:0] op_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] c_cnt_one = {{(CNTW-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_prio;
    logic              r_owner;
    logic [XLEN-1:0]   r_sh_data;
    logic [SHW-1:0]    r_sh_shamt;
    logic              r_sh_l_or_r;
    logic              r_sh_a_or_l;
    logic [XLEN-1:0]   r_result;
    logic [CNTW-1:0]   r_op_count;

    logic              w_grant0;
    logic              w_grant1;
    logic              w_accept_ok;
    logic              w_accept;
    logic              w_resp_hs;

    // Ready is gated by rst_n so no handshake can be seen while in reset.
    always_comb begin
        w_grant0     = r0_req_valid & (~r1_req_valid | ~r_prio);
        w_grant1     = r1_req_valid & (~r0_req_valid |  r_prio);
        w_accept_ok  = (r_state == ST_IDLE) & ~flush & rst_n;
        r0_req_ready = w_accept_ok & w_grant0;
        r1_req_ready = w_accept_ok & w_grant1;
        w_accept     = r0_req_ready | r1_req_ready;
        w_resp_hs    = (r_state == ST_RESP) & ~flush &
                       (r_owner ? r1_resp_ready : r0_resp_ready);

        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)  w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = flush ? ST_IDLE : ST_RESP;
            ST_RESP:  if (flush || w_resp_hs) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= 1'b0;
            r_sh_data   <= '0;
            r_sh_shamt  <= '0;
            r_sh_l_or_r <= 1'b0;
            r_sh_a_or_l <= 1'b0;
        end else if (w_accept) begin
            r_owner     <= r1_req_ready;
            r_sh_data   <= r1_req_ready ? r1_req_data   : r0_req_data;
            r_sh_shamt  <= r1_req_ready ? r1_req_shamt  : r0_req_shamt;
            r_sh_l_or_r <= r1_req_ready ? r1_req_l_or_r : r0_req_l_or_r;
            r_sh_a_or_l <= r1_req_ready ? r1_req_a_or_l : r0_req_a_or_l;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
        end else if ((r_state == ST_ISSUE) && !flush) begin
            r_result <= sh_out_q;
        end
    end

    // A flushed response never completes, so prio and the count stay put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio     <= 1'b0;
            r_op_count <= '0;
        end else if (w_resp_hs) begin
            r_prio     <= ~r_owner;
            r_op_count <= r_op_count + c_cnt_one;
        end
    end

    assign r0_resp_valid = (r_state == ST_RESP) & ~r_owner;
    assign r1_resp_valid = (r_state == ST_RESP) &  r_owner;
    assign r0_resp_data  = r_result;
    assign r1_resp_data  = r_result;
    assign sh_data       = r_sh_data;
    assign sh_shamt      = r_sh_shamt;
    assign sh_l_or_r     = r_sh_l_or_r;
    assign sh_a_or_l     = r_sh_a_or_l;
    assign busy          = (r_state != ST_IDLE);
    assign op_count      = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_shift_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sched
// Purpose  : Directed self-checking bench for shift_sched with a shifter model.
// Revision : 1.0
// ============================================================================
module tb_shift_sched;

    localparam int XLEN = 32;
    localparam int SHW  = 5;
    // Narrow counter keeps the wrap-around scenario short.
    localparam int CNTW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    logic [1:0]           req_valid  = '0;
    logic [1:0]           resp_ready = '0;
    logic [1:0]           req_l_or_r = '0;
    logic [1:0]           req_a_or_l = '0;
    logic [1:0][XLEN-1:0] req_data   = '0;
    logic [1:0][SHW-1:0]  req_shamt  = '0;

    logic [1:0]      req_ready;
    logic [1:0]      resp_valid;
    logic [XLEN-1:0] resp_data0, resp_data1;
    logic [XLEN-1:0] sh_data, sh_out_q;
    logic [SHW-1:0]  sh_shamt;
    logic            sh_l_or_r, sh_a_or_l, busy;
    logic [CNTW-1:0] op_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Model of the external shifter.
    always_comb begin
        if (sh_l_or_r)      sh_out_q = sh_data << sh_shamt;
        else if (sh_a_or_l) sh_out_q = XLEN'($signed(sh_data) >>> sh_shamt);
        else                sh_out_q = sh_data >> sh_shamt;
    end

    shift_sched #(.XLEN(XLEN), .SHW(SHW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .r0_req_valid(req_valid[0]), .r0_req_ready(req_ready[0]),
        .r0_req_data(req_data[0]), .r0_req_shamt(req_shamt[0]),
        .r0_req_l_or_r(req_l_or_r[0]), .r0_req_a_or_l(req_a_or_l[0]),
        .r0_resp_valid(resp_valid[0]), .r0_resp_ready(resp_ready[0]),
        .r0_resp_data(resp_data0),
        .r1_req_valid(req_valid[1]), .r1_req_ready(req_ready[1]),
        .r1_req_data(req_data[1]), .r1_req_shamt(req_shamt[1]),
        .r1_req_l_or_r(req_l_or_r[1]), .r1_req_a_or_l(req_a_or_l[1]),
        .r1_resp_valid(resp_valid[1]), .r1_resp_ready(resp_ready[1]),
        .r1_resp_data(resp_data1),
        .sh_data(sh_data), .sh_shamt(sh_shamt), .sh_l_or_r(sh_l_or_r),
        .sh_a_or_l(sh_a_or_l), .sh_out_q(sh_out_q),
        .busy(busy), .op_count(op_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] resp_data_of(input int p);
        return (p == 0) ? resp_data0 : resp_data1;
    endfunction

    task automatic set_req(input int p, input logic [31:0] d, input logic [4:0] s,
                           input logic lr, input logic al);
        req_data[p]   = d;
        req_shamt[p]  = s;
        req_l_or_r[p] = lr;
        req_a_or_l[p] = al;
        req_valid[p]  = 1'b1;
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic accept(input int p, input string tag);
        int n = 0;
        #1;
        while (req_ready[p] !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check({tag, ".ready"}, 32'(req_ready[p]), 32'd1);
        check({tag, ".other_ready"}, 32'(req_ready[1-p]), 32'd0);
        @(negedge clk);
        req_valid[p] = 1'b0;
    endtask

    task automatic serve(input int p, input logic [31:0] exp, input string tag);
        logic [1:0] expv;
        expv = (p == 0) ? 2'b01 : 2'b10;
        accept(p, tag);
        check({tag, ".sh_data"}, sh_data, req_data[p]);
        check({tag, ".busy"}, 32'(busy), 32'd1);
        check({tag, ".issue_valid"}, 32'(resp_valid), 32'd0);
        @(negedge clk);
        check({tag, ".resp_valid"}, 32'(resp_valid), 32'(expv));
        check({tag, ".resp_data"}, resp_data_of(p), exp);
        resp_ready[p] = 1'b1;
        @(negedge clk);
        resp_ready[p] = 1'b0;
        check({tag, ".resp_done"}, 32'(resp_valid), 32'd0);
        check({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset state, with requests already asserted to probe ready gating.
        set_req(0, 32'h0000_0003, 5'd2, 1'b1, 1'b0);
        set_req(1, 32'h0000_00F0, 5'd4, 1'b0, 1'b0);
        #12;
        check("rst.req_ready", 32'(req_ready), 32'd0);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.sh_data", sh_data, 32'd0);
        check("rst.sh_ctl", {25'd0, sh_shamt, sh_l_or_r, sh_a_or_l}, 32'd0);
        check("rst.resp_data", resp_data0 | resp_data1, 32'd0);
        check("rst.op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Both valid right after reset: port 0 then port 1, twice.
        serve(0, 32'h0000_000C, "arb1.p0");
        serve(1, 32'h0000_000F, "arb1.p1");
        set_req(0, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b0);
        set_req(1, 32'h8000_0000, 5'd31, 1'b0, 1'b1);
        serve(0, 32'h8000_0000, "arb2.p0");
        serve(1, 32'hFFFF_FFFF, "arb2.p1");
        check("arb.op_count", 32'(op_count), 32'd4);

        // Shift kinds on port 0.
        set_req(0, 32'h8000_0001, 5'd4, 1'b1, 1'b0);
        serve(0, 32'h0000_0010, "sh.left");
        set_req(0, 32'h8000_0001, 5'd4, 1'b0, 1'b0);
        serve(0, 32'h0800_0000, "sh.right_log");
        set_req(0, 32'h8000_0001, 5'd4, 1'b0, 1'b1);
        serve(0, 32'hF800_0000, "sh.right_ari");
        check("sh.sh_shamt", 32'(sh_shamt), 32'd4);

        // Backpressure on port 1 while port 0 waits.
        set_req(1, 32'h1234_5678, 5'd8, 1'b0, 1'b0);
        accept(1, "bp.p1");
        set_req(0, 32'h0000_00FF, 5'd8, 1'b1, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp.resp_valid", 32'(resp_valid), 32'd2);
            check("bp.resp_data", resp_data1, 32'h0012_3456);
            check("bp.p0_ready", 32'(req_ready[0]), 32'd0);
            @(negedge clk);
        end
        resp_ready[1] = 1'b1;
        @(negedge clk);
        resp_ready[1] = 1'b0;
        serve(0, 32'h0000_FF00, "bp.p0");
        check("bp.op_count", 32'(op_count), 32'd9);

        // Flush in ISSUE, in RESP, then in IDLE with a pending request.
        set_req(0, 32'hAAAA_5555, 5'd1, 1'b1, 1'b0);
        accept(0, "fl.issue");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fl.issue.busy", 32'(busy), 32'd0);
        check("fl.issue.resp_valid", 32'(resp_valid), 32'd0);
        set_req(0, 32'hAAAA_5555, 5'd1, 1'b1, 1'b0);
        accept(0, "fl.resp");
        @(negedge clk);
        check("fl.resp.pre", 32'(resp_valid), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fl.resp.busy", 32'(busy), 32'd0);
        check("fl.resp.resp_valid", 32'(resp_valid), 32'd0);
        check("fl.op_count", 32'(op_count), 32'd9);
        flush = 1'b1;
        set_req(0, 32'hF0F0_F0F0, 5'd4, 1'b0, 1'b1);
        #1;
        check("fl.idle.ready", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        serve(0, 32'hFF0F_0F0F, "fl.after");
        check("fl.after.op_count", 32'(op_count), 32'd10);

        // Asynchronous reset while a response is pending.
        set_req(1, 32'h1111_1111, 5'd2, 1'b1, 1'b0);
        accept(1, "ar");
        @(negedge clk);
        check("ar.pre", 32'(resp_valid), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.resp_valid", 32'(resp_valid), 32'd0);
        check("ar.busy", 32'(busy), 32'd0);
        check("ar.sh_data", sh_data, 32'd0);
        check("ar.resp_data", resp_data1, 32'd0);
        check("ar.op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0);
        serve(0, 32'hDEAD_BEEF, "ar.shamt0");
        check("ar.op_count_after", 32'(op_count), 32'd1);

        // Counter wrap: fill to all-ones, then one more.
        for (int i = 0; i < 254; i++) begin
            set_req(i % 2, 32'(i), 5'd1, 1'b1, 1'b0);
            serve(i % 2, 32'(i) << 1, "wrap.fill");
        end
        check("wrap.full", 32'(op_count), 32'h0000_00FF);
        set_req(0, 32'h0000_0001, 5'd31, 1'b1, 1'b0);
        serve(0, 32'h8000_0000, "wrap.last");
        check("wrap.zero", 32'(op_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
